// File: rtl/tf_mem_loader_pkg.sv
// Shared constants, state encoding and helpers for the twiddle-factor RAM loader.
// Latency: none (declarations only).
// Backpressure: n/a.
package tf_pkg;

   // Table geometry: 213 entries, addressed by an 8-bit read/write pointer
   localparam int TF_DEPTH = 213;
   localparam int TF_AW    = 8;

   // Layout shared with the address generator: entry 0, then NTT regions
   // starting at these bases, with the INTT mirror regions ending at the tops
   localparam int TF_NTT_BASE_0 = 1;
   localparam int TF_NTT_BASE_1 = 5;
   localparam int TF_NTT_BASE_2 = 21;
   localparam int TF_NTT_BASE_3 = 85;
   localparam int TF_INTT_TOP_0 = 4;
   localparam int TF_INTT_TOP_1 = 20;
   localparam int TF_INTT_TOP_2 = 84;
   localparam int TF_INTT_TOP_3 = 212;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      READY = 2'd2
   } tf_ld_state_t;

   // True when an address falls inside a table of the given depth
   function automatic logic tf_addr_in_range(input logic [TF_AW-1:0] addr, input int depth);
      return int'(addr) < depth;
   endfunction

endpackage

// File: rtl/tf_mem_loader_ram.sv
// Twiddle-factor RAM: one synchronous write port, one registered read port, read-before-write.
// Latency: 1 cycle address-to-data; out-of-range reads return 0 with rd_oob set.
// Backpressure: none, accepts a write and a read every cycle.
module tf_ram
   import tf_pkg::*;
#(
   parameter int DATA_W = 12,
   parameter int DEPTH  = TF_DEPTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [TF_AW-1:0]  wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [TF_AW-1:0]  rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_oob
);

   // Storage is deliberately left unreset so it maps onto a plain RAM macro
   logic [DATA_W-1:0] mem [DEPTH];

   logic rd_in_range;
   assign rd_in_range = tf_addr_in_range(rd_addr, DEPTH);

   // Write port; the loader never presents an address past DEPTH-1
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Registered read; sampling mem before the write lands gives read-before-write
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_data <= '0;
         rd_oob  <= 1'b0;
      end else if (rd_in_range) begin
         rd_data <= mem[rd_addr];
         rd_oob  <= 1'b0;
      end else begin
         rd_data <= '0;
         rd_oob  <= 1'b1;
      end
   end

endmodule

// File: rtl/tf_mem_loader.sv
// Twiddle-factor table loader: streams DEPTH words into tf_ram, owns its read port (optional TF_LOAD_CHECKSUM_EN).
// Latency: s_ready one cycle after start; 1 word/cycle load; tf_data one cycle after tf_address.
// Backpressure: s_ready high only while loading; reads are never blocked, qualify tf_data with loaded.
module tf_mem_loader
   import tf_pkg::*;
#(
   parameter int DATA_W = 12,
   parameter int DEPTH  = TF_DEPTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              s_valid,
   input  logic [DATA_W-1:0] s_data,
   output logic              s_ready,
   input  logic [TF_AW-1:0]  tf_address,
   output logic [DATA_W-1:0] tf_data,
   output logic              busy,
   output logic              loaded,
   output logic              done,
   output logic              rd_oob
`ifdef TF_LOAD_CHECKSUM_EN
   ,
   output logic [15:0]       checksum
`endif
);

   localparam logic [TF_AW-1:0] LAST_ADDR = TF_AW'(DEPTH - 1);

   tf_ld_state_t      state;
   logic [TF_AW-1:0]  wr_cnt;
   logic              xfer;

   // s_ready is a registered copy of (state == LOAD), so it doubles as the handshake qualifier
   assign xfer = s_valid && s_ready;

   // Load FSM with registered status outputs; start always wins, even over the final word
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         wr_cnt  <= '0;
         s_ready <= 1'b0;
         busy    <= 1'b0;
         loaded  <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            state   <= LOAD;
            wr_cnt  <= '0;
            s_ready <= 1'b1;
            busy    <= 1'b1;
            loaded  <= 1'b0;
         end else begin
            case (state)
               LOAD: begin
                  if (xfer) begin
                     if (wr_cnt == LAST_ADDR) begin
                        state   <= READY;
                        s_ready <= 1'b0;
                        busy    <= 1'b0;
                        loaded  <= 1'b1;
                        done    <= 1'b1;
                     end else begin
                        wr_cnt <= wr_cnt + TF_AW'(1);
                     end
                  end
               end
               default: begin
                  // IDLE and READY hold until the next start
               end
            endcase
         end
      end
   end

`ifdef TF_LOAD_CHECKSUM_EN
   // Running mod-2^16 sum of accepted words; a start in the same cycle as a transfer clears it
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         checksum <= '0;
      end else if (start) begin
         checksum <= '0;
      end else if (xfer) begin
         checksum <= checksum + 16'(s_data);
      end
   end
`endif

   tf_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (xfer),
      .wr_addr (wr_cnt),
      .wr_data (s_data),
      .rd_addr (tf_address),
      .rd_data (tf_data),
      .rd_oob  (rd_oob)
   );

endmodule

// File: tb/tb_tf_mem_loader.sv
// Bench for tf_mem_loader: randomized loads and reads checked against a word-level table model.
// Latency: n/a.
// Backpressure: drives s_valid with random gaps.
module tb_tf_mem_loader;
   import tf_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        s_valid = 1'b0;
   logic [11:0] s_data = '0;
   logic [7:0]  tf_address = '0;
   logic        s_ready;
   logic [11:0] tf_data;
   logic        busy;
   logic        loaded;
   logic        done;
   logic        rd_oob;
`ifdef TF_LOAD_CHECKSUM_EN
   logic [15:0] checksum;
`endif

   tf_mem_loader #(.DATA_W(12), .DEPTH(TF_DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .s_valid    (s_valid),
      .s_data     (s_data),
      .s_ready    (s_ready),
      .tf_address (tf_address),
      .tf_data    (tf_data),
      .busy       (busy),
      .loaded     (loaded),
      .done       (done),
      .rd_oob     (rd_oob)
`ifdef TF_LOAD_CHECKSUM_EN
      ,
      .checksum   (checksum)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // Reference model: the table as an array of words plus "how many words so far"
   int m_mem [256];
   bit m_known [256];
   bit m_loading, m_loaded, m_done;
   int m_cnt, m_sum;
   int e_tf;
   bit e_oob, e_tf_known;

   // Per-scenario observation counters
   int edge_idx, rdy_cnt, done_cnt, done_at;

   task automatic model_reset();
      m_loading = 0; m_loaded = 0; m_done = 0;
      m_cnt = 0; m_sum = 0;
      e_tf = 0; e_oob = 0; e_tf_known = 1;
   endtask

   task automatic model_edge(input bit st, input bit v, input logic [11:0] d, input logic [7:0] a);
      bit acc;
      if (int'(a) >= TF_DEPTH) begin
         e_tf = 0; e_oob = 1; e_tf_known = 1;
      end else begin
         e_tf = m_mem[a]; e_oob = 0; e_tf_known = m_known[a];
      end
      acc = m_loading && v;
      m_done = 0;
      if (acc) begin
         m_mem[m_cnt] = int'(d);
         m_known[m_cnt] = 1;
         m_sum = (m_sum + int'(d)) % 65536;
         m_cnt++;
      end
      if (st) begin
         m_loading = 1; m_loaded = 0; m_cnt = 0; m_sum = 0;
      end else if (acc && m_cnt == TF_DEPTH) begin
         m_loading = 0; m_loaded = 1; m_done = 1;
      end
   endtask

   task automatic compare_all();
      check("s_ready", 32'(s_ready), 32'(m_loading));
      check("busy",    32'(busy),    32'(m_loading));
      check("loaded",  32'(loaded),  32'(m_loaded));
      check("done",    32'(done),    32'(m_done));
      check("rd_oob",  32'(rd_oob),  32'(e_oob));
      if (e_tf_known) check("tf_data", 32'(tf_data), e_tf);
`ifdef TF_LOAD_CHECKSUM_EN
      if (m_loaded) check("checksum", 32'(checksum), m_sum);
`endif
   endtask

   // One clock: drive at negedge, model the edge, sample 1 ns later, return at next negedge
   task automatic cyc(input bit st, input bit v, input logic [11:0] d, input logic [7:0] a);
      start = st; s_valid = v; s_data = d; tf_address = a;
      @(posedge clk);
      model_edge(st, v, d, a);
      #1;
      compare_all();
      edge_idx++;
      if (s_ready) rdy_cnt++;
      if (done) begin done_cnt++; done_at = edge_idx - 1; end
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic rd(input int a, input int exp, input string tag);
      cyc(0, 0, 12'h0, 8'(a));
      check(tag, 32'(tf_data), exp);
   endtask

   task automatic begin_scn();
      edge_idx = 0; rdy_cnt = 0; done_cnt = 0; done_at = -1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_s_ready"}, 32'(s_ready), 0);
      check({tag, "_busy"},    32'(busy),    0);
      check({tag, "_loaded"},  32'(loaded),  0);
      check({tag, "_done"},    32'(done),    0);
      check({tag, "_tf_data"}, 32'(tf_data), 0);
      check({tag, "_rd_oob"},  32'(rd_oob),  0);
   endtask

   initial begin
      int idx;
      for (int i = 0; i < 256; i++) begin m_mem[i] = 0; m_known[i] = 0; end
      model_reset();

      // Reset state
      #2 rst = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b1;
      @(negedge clk);

      // Full load, values = address+1, s_valid held high
      begin_scn();
      cyc(1, 0, 12'h0, 8'($urandom));
      for (int i = 0; i < TF_DEPTH; i++) cyc(0, 1, 12'(i + 1), 8'($urandom));
      cyc(0, 1, 12'hFFF, 8'($urandom));
      check("s1_rdy_cycles", rdy_cnt, 213);
      check("s1_done_pulses", done_cnt, 1);
      check("s1_done_edge", done_at, 213);
      check("s1_loaded", 32'(loaded), 1);
      rd(0, 1, "s1_rd_0");
      rd(TF_NTT_BASE_3, 86, "s1_rd_85");
      rd(TF_INTT_TOP_3, 213, "s1_rd_212");
      rd(TF_NTT_BASE_0, 2, "s1_rd_base0");
      rd(TF_NTT_BASE_1, 6, "s1_rd_base1");
      rd(TF_NTT_BASE_2, 22, "s1_rd_base2");
      rd(TF_INTT_TOP_0, 5, "s1_rd_top0");
      rd(TF_INTT_TOP_1, 21, "s1_rd_top1");
      rd(TF_INTT_TOP_2, 85, "s1_rd_top2");

      // Reload from READY with s_valid toggling every other cycle
      begin_scn();
      idx = 0;
      cyc(1, 0, 12'h0, 8'($urandom));
      for (int k = 1; k <= 2 * TF_DEPTH; k++) begin
         if (k % 2 == 0) begin
            cyc(0, 1, 12'(idx + 1), 8'($urandom));
            idx++;
         end else begin
            cyc(0, 0, 12'($urandom), 8'($urandom));
         end
      end
      cyc(0, 0, 12'h0, 8'h0);
      check("s2_done_edge", done_at, 426);
      check("s2_done_pulses", done_cnt, 1);
      check("s2_loaded", 32'(loaded), 1);
      for (int a = 0; a < TF_DEPTH; a++) rd(a, a + 1, "s2_contents");

      // Out-of-range reads
      cyc(0, 0, 12'h0, 8'd213);
      check("oob_213_data", 32'(tf_data), 0);
      check("oob_213_flag", 32'(rd_oob), 1);
      cyc(0, 0, 12'h0, 8'd255);
      check("oob_255_data", 32'(tf_data), 0);
      check("oob_255_flag", 32'(rd_oob), 1);
      cyc(0, 0, 12'h0, 8'd212);
      check("oob_212_flag", 32'(rd_oob), 0);
      check("oob_212_data", 32'(tf_data), 213);

      // Random gaps, reset after 100 words; reads often target the word being written
      begin_scn();
      idx = 0;
      cyc(1, 0, 12'h0, 8'($urandom));
      for (int k = 0; k < 2000 && idx < 100; k++) begin
         bit v;
         v = 1'($urandom_range(0, 1));
         cyc(0, v, 12'($urandom), $urandom_range(0, 1) ? 8'(m_cnt) : 8'($urandom));
         if (v) idx++;
      end
      check("s3_words_before_reset", idx, 100);
      #2 rst = 1'b0;
      #1;
      model_reset();
      check_reset_outputs("async_reset");
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // Fresh random load after the reset
      begin_scn();
      cyc(1, 0, 12'h0, 8'($urandom));
      for (int k = 0; k < 3000 && !m_loaded; k++) begin
         cyc(0, $urandom_range(0, 3) != 0, 12'($urandom),
             $urandom_range(0, 1) ? 8'(m_cnt) : 8'($urandom));
      end
      check("s3_loaded", 32'(loaded), 1);
      check("s3_done_pulses", done_cnt, 1);
      for (int k = 0; k < 40; k++) cyc(0, 1'($urandom), 12'($urandom), 8'($urandom));

      // Restart mid-load, then start colliding with the final word
      begin_scn();
      cyc(1, 0, 12'h0, 8'h0);
      for (int i = 0; i < 50; i++) cyc(0, 1, 12'($urandom), 8'($urandom));
      cyc(1, 0, 12'h0, 8'h0);
      for (int i = 0; i < TF_DEPTH - 1; i++) cyc(0, 1, 12'(i + 1), 8'($urandom));
      cyc(1, 1, 12'(TF_DEPTH), 8'h0);
      check("collide_no_done", 32'(done), 0);
      check("collide_still_ready", 32'(s_ready), 1);
      check("collide_not_loaded", 32'(loaded), 0);
      begin_scn();
      for (int i = 0; i < TF_DEPTH; i++) cyc(0, 1, 12'(i + 1), 8'($urandom));
      cyc(0, 0, 12'h0, 8'h0);
      check("s4_loaded", 32'(loaded), 1);
      check("s4_done_pulses", done_cnt, 1);
`ifdef TF_LOAD_CHECKSUM_EN
      check("s4_checksum", 32'(checksum), 22791);
`endif
      rd(TF_INTT_TOP_3, 213, "s4_rd_212");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/tf_mem_loader.md
# tf_mem_loader

Write-side companion of the twiddle-factor address generator. It accepts a stream of twiddle factors over a valid/ready handshake and writes them into the twiddle-factor RAM at addresses 0..212. The RAM layout is the one the address generator reads from: address 0 first, then the NTT regions at 1, 5, 21 and 85, with the INTT mirror regions ending at 4, 20, 84 and 212. The block also owns the RAM read port: it returns data for the generator's registered `tf_address` one cycle later, and reports when the table is valid for butterfly use.

## Interface
- `DATA_W`, 12: twiddle-factor word width.
- `DEPTH`, 213: number of RAM entries, addresses 0..DEPTH-1. Must be ≤ 256.
- `clk`  in  1: single clock. All flops are rising-edge.
- `rst`  in  1: asynchronous, active-low reset.
- `start`  in  1: one-cycle pulse. Begins a (re)load.
- `s_valid`  in  1: a load word is present.
- `s_data`  in  DATA_W: the load word.
- `s_ready`  out  1: loader accepts a word this cycle.
- `tf_address`  in  8: read address, driven by the address generator.
- `tf_data`  out  DATA_W: registered read data.
- `busy`  out  1: a load is in progress.
- `loaded`  out  1: table is complete and valid.
- `done`  out  1: one-cycle pulse when the last word is written.
- `rd_oob`  out  1: registered flag; the last read address was ≥ DEPTH.

## Operation
- FSM states are IDLE, LOAD and READY.
  - IDLE to LOAD on `start`.
  - LOAD to READY when word DEPTH-1 is accepted.
  - READY to LOAD on `start`.
  - `start` in LOAD restarts the load: the counter clears to 0, and RAM contents already written are kept but will be overwritten.
- `s_ready` = (state == LOAD). A transfer occurs when `s_valid && s_ready`.
- On each transfer:
  - RAM[wr_cnt] ← `s_data`.
  - wr_cnt increments. wr_cnt is 8 bits and runs 0..DEPTH-1; it never wraps past DEPTH-1 because the state leaves LOAD.
- `s_data` is ignored when no transfer occurs, and `s_valid` is ignored outside LOAD.
- `busy` = (state == LOAD).
- `loaded` = (state == READY).
- `done` is asserted in the cycle after the final transfer, i.e. the first READY cycle.
- Read path:
  - `tf_data` ← RAM[`tf_address`] on every clock, regardless of state.
  - For out-of-range addresses (≥ DEPTH), `tf_data` ← 0 and `rd_oob` ← 1; otherwise `rd_oob` ← 0.
- A read of the address being written in the same cycle returns the old contents (read-before-write).
- Consumers must qualify `tf_data` with `loaded`. The loader does not block reads.

## Timing
- Reset values:
  - state = IDLE, wr_cnt = 0.
  - `s_ready` = 0, `busy` = 0, `loaded` = 0, `done` = 0.
  - `tf_data` = 0, `rd_oob` = 0.
  - RAM contents are not reset.
- Reset asserted mid-load returns to IDLE immediately. Partial contents remain, and `loaded` = 0 until a full load completes.
- `s_ready` rises the cycle after `start` is sampled.
- Load throughput is 1 word/cycle. A full load takes a minimum of DEPTH cycles after the `start` cycle.
- Read latency is 1 cycle from `tf_address` to `tf_data`. Total TF latency from the generator's `k`/`p` inputs is therefore 2 cycles.
- `start` and the final transfer in the same cycle: `start` wins, and the FSM restarts the load at wr_cnt = 0 with no `done`.

## Configuration
- `TF_LOAD_CHECKSUM_EN`, defined:
  - Adds output `checksum` (out, 16): the mod-2^16 sum of all words accepted since the last `start`.
  - It clears on `start` and on reset, and is stable and valid while `loaded`.
- Not defined: the port and its accumulator are absent. All other behaviour is identical.

## Structure
- Package `tf_pkg`:
  - `TF_DEPTH` = 213 and `TF_AW` = 8.
  - Region-base constants: NTT bases 1, 5, 21, 85; INTT tops 4, 20, 84, 212.
  - State enum `tf_ld_state_t` with values IDLE, LOAD, READY.
- Sub-module `tf_ram`:
  - Parameters `DATA_W`, `DEPTH`.
  - One synchronous write port and one registered read port, read-before-write, with out-of-range zero.
- The loader holds the FSM, the counter, the handshake, and the optional checksum.

## Test plan
- Reset, then `start`, then 213 words with value = address+1 and `s_valid` held high → `s_ready` high for exactly 213 cycles, `done` pulses once, `loaded` = 1.
- After the load, apply `tf_address` = 0, 85, 212 → `tf_data` = 1, 86, 213 one cycle later.
- `s_valid` toggled every other cycle during the load → `done` after 426 cycles, and contents are the same as in the first scenario.
- `tf_address` = 213 and 255 → `tf_data` = 0 and `rd_oob` = 1 one cycle later. `tf_address` = 212 → `rd_oob` = 0.
- Reset asserted after 100 words → outputs return to reset values asynchronously. A new `start` plus 213 words gives `loaded` = 1.
- With `TF_LOAD_CHECKSUM_EN`, load words = address+1 → `checksum` = 22791 (0x5907).
